// File: rtl/multi_timer.sv
// ============================================================================
// Module   : multi_timer
// Purpose  : CHANNELS independent down-counting timers with CTRL/PRESET/COUNT/
//            STATUS registers per channel. Define TIMER_PRESCALE_EN to add an
//            8-bit per-channel prescaler in CTRL[15:8].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_timer #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 32,
    parameter int ADDR_W   = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                Timer_Wr,
    input  logic [31:0]         DataIn,
    output logic [31:0]         DataOut,
    output logic [CHANNELS-1:0] Timer_IRQ,
    output logic                IntReq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2
    } state_t;

    logic [ADDR_W-1:0]        sel_ch;
    logic [CHANNELS-1:0][31:0] ch_rdata;
    logic                     unused_data;

    assign sel_ch      = addr >> 2;
    assign unused_data = ^DataIn;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic             en;
        logic             im;
        logic [1:0]       mode;
        logic [CNT_W-1:0] preset;
        logic [CNT_W-1:0] count;
        logic             pend;
        state_t           state;
        logic             tick;
        logic             sel;
        logic             wr_ctrl;
        logic             wr_preset;
        logic             wr_count;
        logic             wr_status;
        logic             stop;
        logic             fire;
        logic [7:0]       psc_rd;
        logic [31:0]      rdata;

`ifdef TIMER_PRESCALE_EN
        logic [7:0] psc;
        logic [7:0] psc_cnt;
        // >= rather than == so lowering PSC mid-count cannot strand the divider
        assign tick   = (psc_cnt >= psc);
        assign psc_rd = psc;
`else
        assign tick   = 1'b1;
        assign psc_rd = 8'h00;
`endif

        assign sel       = Timer_Wr && (sel_ch == ADDR_W'(g));
        assign wr_ctrl   = sel && (addr[1:0] == 2'd0);
        assign wr_preset = sel && (addr[1:0] == 2'd1);
        assign wr_count  = sel && (addr[1:0] == 2'd2);
        assign wr_status = sel && (addr[1:0] == 2'd3);
        assign stop      = wr_ctrl && !DataIn[0];
        // A same-cycle COUNT write or disable suppresses the terminal event
        assign fire      = (state == S_CNT) && tick && (count <= CNT_W'(1))
                           && !stop && !wr_count;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                en     <= 1'b0;
                im     <= 1'b0;
                mode   <= 2'b00;
                preset <= '0;
                count  <= '0;
                pend   <= 1'b0;
                state  <= S_IDLE;
`ifdef TIMER_PRESCALE_EN
                psc     <= 8'h00;
                psc_cnt <= 8'h00;
`endif
            end else begin
                if (!stop) begin
                    case (state)
                        S_IDLE: ;
                        S_LOAD: begin
                            count <= preset;
                            state <= S_CNT;
`ifdef TIMER_PRESCALE_EN
                            psc_cnt <= 8'h00;
`endif
                        end
                        S_CNT: begin
`ifdef TIMER_PRESCALE_EN
                            psc_cnt <= tick ? 8'h00 : psc_cnt + 8'd1;
`endif
                            if (tick && (count > CNT_W'(1))) begin
                                count <= count - CNT_W'(1);
                            end else if (fire) begin
                                count <= '0;
                                if (mode == 2'b01) begin
                                    state <= S_LOAD;
                                end else begin
                                    en    <= 1'b0;
                                    state <= S_IDLE;
                                end
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end

                if (fire)
                    pend <= 1'b1;
                else if (wr_status && DataIn[0])
                    pend <= 1'b0;

                // CPU writes come last so they override the timer's own update
                if (wr_ctrl) begin
                    en   <= DataIn[0];
                    mode <= DataIn[2:1];
                    im   <= DataIn[3];
`ifdef TIMER_PRESCALE_EN
                    psc  <= DataIn[15:8];
`endif
                    if (!DataIn[0])
                        state <= S_IDLE;
                    else if ((state == S_IDLE) || fire)
                        state <= S_LOAD;
                end
                if (wr_preset)
                    preset <= DataIn[CNT_W-1:0];
                if (wr_count)
                    count <= DataIn[CNT_W-1:0];
            end
        end

        always_comb begin
            case (addr[1:0])
                2'd0:    rdata = {16'h0000, psc_rd, 4'h0, im, mode, en};
                2'd1:    rdata = 32'(preset);
                2'd2:    rdata = 32'(count);
                default: rdata = {31'd0, pend};
            endcase
        end

        assign ch_rdata[g]  = rdata;
        assign Timer_IRQ[g] = pend & im;
    end

    always_comb begin
        DataOut = 32'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_ch == ADDR_W'(i))
                DataOut = ch_rdata[i];
        end
    end

    assign IntReq = |Timer_IRQ;

endmodule

`default_nettype wire

// File: tb/tb_multi_timer.sv
// ============================================================================
// Module   : tb_multi_timer
// Purpose  : directed self-checking bench for multi_timer (2 channels, 32-bit)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_timer;

    logic        clk;
    logic        reset;
    logic [2:0]  addr;
    logic        Timer_Wr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic [1:0]  Timer_IRQ;
    logic        IntReq;

    int total = 0;
    int bad   = 0;

    multi_timer #(
        .CHANNELS(2),
        .CNT_W   (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .Timer_Wr (Timer_Wr),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Timer_IRQ(Timer_IRQ),
        .IntReq   (IntReq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // advance n rising edges, leaving time 1ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // the write lands on the next rising edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr     = a;
        DataIn   = d;
        Timer_Wr = 1'b1;
        @(posedge clk);
        #1;
        Timer_Wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = DataOut;
    endtask

    logic [31:0] v;

    initial begin
        reset    = 1'b0;
        addr     = 3'd0;
        Timer_Wr = 1'b0;
        DataIn   = 32'd0;

        // reset state
        #12;
        check("rst_irq", 32'(Timer_IRQ), 32'd0);
        check("rst_intreq", 32'(IntReq), 32'd0);
        rd(3'd0, v); check("rst_ctrl0", v, 32'd0);
        rd(3'd6, v); check("rst_count1", v, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1);

        // one-shot: PRESET=5, CTRL=0x9
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            rd(3'd2, v); check($sformatf("os_count_E%0d", k), v, 32'(6 - k));
            if (k == 5) check("os_irq_early", 32'(Timer_IRQ), 32'd0);
        end
        check("os_irq", 32'(Timer_IRQ), 32'd1);
        check("os_intreq", 32'(IntReq), 32'd1);
        rd(3'd0, v); check("os_ctrl_en0", v, 32'h8);
        step(2);
        rd(3'd2, v); check("os_count_stays", v, 32'd0);
        wr(3'd3, 32'd1);
        check("os_clear_irq", 32'(Timer_IRQ), 32'd0);

        // auto-reload on ch1: PRESET=3, CTRL=0xB, PEND every 4 edges
        wr(3'd5, 32'd3);
        wr(3'd4, 32'hB);
        step(3);
        rd(3'd7, v); check("ar_pend_E3", v, 32'd0);
        step(1);
        rd(3'd7, v); check("ar_pend_E4", v, 32'd1);
        check("ar_irq_E4", 32'(Timer_IRQ), 32'h2);
        rd(3'd0, v); check("ar_ch0_isolated", v, 32'h8);
        rd(3'd1, v); check("ar_ch0_preset", v, 32'd5);
        wr(3'd7, 32'd1);
        check("ar_irq_cleared", 32'(Timer_IRQ), 32'd0);
        rd(3'd6, v); check("ar_reloaded", v, 32'd3);
        step(2);
        rd(3'd6, v); check("ar_counting_E7", v, 32'd1);
        step(1);
        rd(3'd7, v); check("ar_pend_E8", v, 32'd1);
        wr(3'd4, 32'h8);
        wr(3'd7, 32'd1);
        check("ar_stopped_intreq", 32'(IntReq), 32'd0);

        // disable freezes COUNT, re-enable reloads PRESET, COUNT write wins
        wr(3'd1, 32'd10);
        wr(3'd0, 32'h1);
        step(4);
        rd(3'd2, v); check("frz_count7", v, 32'd7);
        wr(3'd0, 32'h8);
        rd(3'd2, v); check("frz_after_stop", v, 32'd7);
        step(3);
        rd(3'd2, v); check("frz_held", v, 32'd7);
        wr(3'd0, 32'h1);
        step(1);
        rd(3'd2, v); check("frz_reload", v, 32'd10);
        wr(3'd2, 32'd100);
        rd(3'd2, v); check("cw_wins", v, 32'd100);
        step(1);
        rd(3'd2, v); check("cw_decrement", v, 32'd99);
        wr(3'd0, 32'h0);

        // PRESET=0 fires 2 edges after enable; clear on the firing edge loses
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h9);
        step(1);
        rd(3'd3, v); check("p0_pend_E1", v, 32'd0);
        wr(3'd3, 32'd1);
        rd(3'd3, v); check("p0_set_wins", v, 32'd1);
        check("p0_irq", 32'(Timer_IRQ), 32'd1);
        wr(3'd3, 32'd1);
        check("p0_cleared", 32'(Timer_IRQ), 32'd0);

        // asynchronous reset mid-count
        wr(3'd5, 32'd9);
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h9);
        step(4);
        rd(3'd2, v); check("mr_count2", v, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        rd(3'd2, v); check("mr_count", v, 32'd0);
        rd(3'd0, v); check("mr_ctrl", v, 32'd0);
        rd(3'd1, v); check("mr_preset", v, 32'd0);
        rd(3'd5, v); check("mr_ch1_preset", v, 32'd0);
        check("mr_irq", 32'(Timer_IRQ), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(10);
        check("mr_no_spurious", 32'(Timer_IRQ), 32'd0);
        check("mr_no_intreq", 32'(IntReq), 32'd0);
        rd(3'd3, v); check("mr_pend", v, 32'd0);

        // prescaler field: PSC=2, PRESET=2
        wr(3'd1, 32'd2);
        wr(3'd0, 32'h209);
`ifdef TIMER_PRESCALE_EN
        rd(3'd0, v); check("psc_ctrl", v, 32'h209);
        step(6);
        rd(3'd3, v); check("psc_pend_E6", v, 32'd0);
        step(1);
        rd(3'd3, v); check("psc_pend_E7", v, 32'd1);
`else
        rd(3'd0, v); check("psc_ctrl", v, 32'h009);
        step(2);
        rd(3'd3, v); check("psc_pend_E2", v, 32'd0);
        step(1);
        rd(3'd3, v); check("psc_pend_E3", v, 32'd1);
`endif
        wr(3'd3, 32'd1);
        check("psc_cleared", 32'(IntReq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
